// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: immediate extension mode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SEXT  = 2'b00,
    EXT_ZEXT  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BOFS  = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Valid/ready bundle for the immediate extension stage (input and output sides).
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry stalls toward the producer side.
interface imm_extend_stage_if
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_imm;
  logic [EXT_MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]      in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [TAG_W-1:0]      out_tag;

  // Environment side: offers immediates and consumes results.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Stage side.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/imm_extend_stage_comb.sv
// Combinational immediate extension: SEXT, ZEXT, UPPER, BOFS (sext << 2).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
module imm_extend_comb
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm_i,
  input  logic [EXT_MODE_W-1:0] mode_i,
  output logic [OUT_W-1:0]      ext_o
);

  logic [OUT_W-1:0] sext_w;

  assign sext_w = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  // Mode select; BOFS drops the top two sign bits when shifting.
  always_comb begin
    ext_o = sext_w;
    case (mode_i)
      EXT_SEXT:  ext_o = sext_w;
      EXT_ZEXT:  ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      EXT_UPPER: ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      EXT_BOFS:  ext_o = {sext_w[OUT_W-3:0], 2'b00};
      default:   ext_o = sext_w;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate extension stage with a 2-entry (main + skid) buffer.
// Latency: 1 cycle input transfer to out_valid; full throughput with out_ready high.
// Backpressure: in_ready is registered (!skid occupied), no comb path from out_ready.
module imm_extend_stage
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  imm_extend_stage_if.slave  bus
);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_stage: OUT_W must be >= IN_W+2");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] main_dat_q, main_dat_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [OUT_W-1:0] skid_dat_q, skid_dat_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic [OUT_W-1:0] ext_w;
  logic             in_xfer;
  logic             out_xfer;

  imm_extend_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm_i  (bus.in_imm),
    .mode_i (bus.in_mode),
    .ext_o  (ext_w)
  );

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_dat_q;
  assign bus.out_tag   = main_tag_q;

  assign in_xfer  = bus.in_valid  && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Next state and buffer loads; skid only fills when main is stalled.
  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_tag_d = main_tag_q;
    skid_dat_d = skid_dat_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d    = ST_ONE;
          main_dat_d = ext_w;
          main_tag_d = bus.in_tag;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_dat_d = ext_w;
          main_tag_d = bus.in_tag;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          state_d    = ST_FULL;
          skid_dat_d = ext_w;
          skid_tag_d = bus.in_tag;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_d    = ST_ONE;
          main_dat_d = skid_dat_q;
          main_tag_d = skid_tag_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and data registers; reset discards everything held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_dat_q <= '0;
      main_tag_q <= '0;
      skid_dat_q <= '0;
      skid_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_tag_q <= main_tag_d;
      skid_dat_q <= skid_dat_d;
      skid_tag_q <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Randomized + directed bench for imm_extend_stage against a queue reference model.
// Latency: n/a.
// Backpressure: out_ready is randomized to exercise the skid path.
module tb_imm_extend_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [36:0] exp_q[$];

  imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
  imm_extend_stage_if #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) bus8 ();

  imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  imm_extend_stage #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference extension written as plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] md);
    longint s;
    longint r;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    case (md)
      2'b00:   r = s;
      2'b01:   r = longint'(imm);
      2'b10:   r = longint'(imm) * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  // One cycle: check outputs vs model, drive inputs, advance model at the edge.
  task automatic step(input bit iv, input logic [15:0] imm, input logic [1:0] md,
                      input logic [4:0] tg, input bit ordy);
    logic [36:0] head;
    bit exp_in_rdy;
    bit exp_out_vld;
    @(negedge clk);
    exp_in_rdy  = (exp_q.size() < 2);
    exp_out_vld = (exp_q.size() > 0);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_in_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_out_vld));
    if (exp_out_vld) begin
      head = exp_q[0];
      chk("out_data", 64'(bus.out_data), 64'(head[31:0]));
      chk("out_tag", 64'(bus.out_tag), 64'(head[36:32]));
    end
    bus.in_valid  = iv;
    bus.in_imm    = imm;
    bus.in_mode   = md;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    @(posedge clk);
    if (exp_out_vld && ordy) void'(exp_q.pop_front());
    if (iv && exp_in_rdy) exp_q.push_back({tg, ref_ext(imm, md)});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int cyc;
    bit iv;
    bit ordy;
    logic [15:0] imm;
    logic [1:0]  md;
    logic [4:0]  tg;

    n_checks = 0;
    n_fail   = 0;

    // Reset with input activity that must be ignored.
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_imm     = 16'hFFFF;
    bus.in_mode    = EXT_SEXT;
    bus.in_tag     = 5'd31;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_imm    = 8'h00;
    bus8.in_mode   = EXT_SEXT;
    bus8.in_tag    = 5'd0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_out_data", 64'(bus.out_data), 64'd0);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back modes on one immediate, consumer always ready.
    step(1'b1, 16'h8001, EXT_SEXT, 5'd1, 1'b1);
    #1 chk("sext_8001", 64'(bus.out_data), 64'h0000_0000_FFFF_8001);
    step(1'b1, 16'h8001, EXT_ZEXT, 5'd2, 1'b1);
    #1 chk("zext_8001", 64'(bus.out_data), 64'h0000_0000_0000_8001);
    step(1'b1, 16'h8001, EXT_UPPER, 5'd3, 1'b1);
    #1 chk("upper_8001", 64'(bus.out_data), 64'h0000_0000_8001_0000);
    step(1'b1, 16'h8001, EXT_BOFS, 5'd4, 1'b1);
    #1 chk("bofs_8001", 64'(bus.out_data), 64'h0000_0000_FFFE_0004);
    chk("bofs_tag", 64'(bus.out_tag), 64'd4);
    step(1'b0, 16'h0, EXT_SEXT, 5'd0, 1'b1);
    #1 chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Stalled consumer: second item parks in the skid.
    step(1'b1, 16'h0005, EXT_SEXT, 5'd5, 1'b0);
    #1 chk("stall_first", 64'(bus.out_data), 64'h5);
    step(1'b1, 16'h7FFF, EXT_ZEXT, 5'd6, 1'b0);
    #1 chk("stall_hold", 64'(bus.out_data), 64'h5);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 16'h1234, EXT_UPPER, 5'd7, 1'b0);
    #1 chk("stall_hold2", 64'(bus.out_data), 64'h5);
    step(1'b0, 16'h0, EXT_SEXT, 5'd0, 1'b1);
    #1 chk("unstall_second", 64'(bus.out_data), 64'h7FFF);
    chk("unstall_tag", 64'(bus.out_tag), 64'd6);
    step(1'b0, 16'h0, EXT_SEXT, 5'd0, 1'b1);
    #1 chk("unstall_empty", 64'(bus.out_valid), 64'd0);

    // Random traffic against the queue model.
    accepted = 0;
    cyc      = 0;
    while (accepted < 1000 && cyc < 20000) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      imm  = 16'($urandom);
      md   = 2'($urandom);
      tg   = 5'($urandom);
      if (iv && exp_q.size() < 2) accepted++;
      step(iv, imm, md, tg, ordy);
      cyc++;
    end
    if (accepted < 1000) chk("rand_budget", 64'(accepted), 64'd1000);
    repeat (4) step(1'b0, 16'h0, EXT_SEXT, 5'd0, 1'b1);

    // Reset while FULL drops both entries.
    step(1'b1, 16'h1111, EXT_SEXT, 5'd9, 1'b0);
    step(1'b1, 16'h2222, EXT_ZEXT, 5'd10, 1'b0);
    #1 chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_imm    = 16'h3333;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("full_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("full_rst_data", 64'(bus.out_data), 64'd0);
    chk("full_rst_tag", 64'(bus.out_tag), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) step(1'b0, 16'h0, EXT_SEXT, 5'd0, 1'b1);

    // Narrow instance: 8-bit in, 16-bit out.
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_imm   = 8'h80;
    bus8.in_mode  = EXT_BOFS;
    bus8.in_tag   = 5'd2;
    @(posedge clk);
    #1;
    chk("w8_bofs_80", 64'(bus8.out_data), 64'hFE00);
    chk("w8_bofs_tag", 64'(bus8.out_tag), 64'd2);
    @(negedge clk);
    bus8.in_imm  = 8'h12;
    bus8.in_mode = EXT_UPPER;
    bus8.in_tag  = 5'd3;
    @(posedge clk);
    #1;
    chk("w8_upper_12", 64'(bus8.out_data), 64'h1200);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_empty", 64'(bus8.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
